// File: rtl/dac_min_pkg.sv
// Shared constants, types and helpers for the sequential minimum search.
package dac_min_pkg;

  // Elements handled per cycle by the shared min tree
  localparam int unsigned GRP_SIZE = 6;

  // Default element word width
  localparam int unsigned DEF_W = 4;

  // Index width for n elements; never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Search controller states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StHold = 2'd2
  } state_e;

endpackage

// File: rtl/min6_idx.sv
// Combinational 6-input unsigned minimum with local argmin.
// Three-level pairwise tree; the lower index is kept on ties at every level.
module min6_idx
  import dac_min_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic [GRP_SIZE*W-1:0] data_i,
  output logic [W-1:0]          min_o,
  output logic [2:0]            idx_o
);

  logic [W-1:0] l1_min [3];
  logic [2:0]   l1_idx [3];
  logic [W-1:0] l2_min;
  logic [2:0]   l2_idx;

  // Pairwise tree: (0,1) (2,3) (4,5), then left pairs, then the last pair
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      if (data_i[(2*p+1)*W +: W] < data_i[(2*p)*W +: W]) begin
        l1_min[p] = data_i[(2*p+1)*W +: W];
        l1_idx[p] = 3'(2*p + 1);
      end else begin
        l1_min[p] = data_i[(2*p)*W +: W];
        l1_idx[p] = 3'(2*p);
      end
    end

    if (l1_min[1] < l1_min[0]) begin
      l2_min = l1_min[1];
      l2_idx = l1_idx[1];
    end else begin
      l2_min = l1_min[0];
      l2_idx = l1_idx[0];
    end

    if (l1_min[2] < l2_min) begin
      min_o = l1_min[2];
      idx_o = l1_idx[2];
    end else begin
      min_o = l2_min;
      idx_o = l2_idx;
    end
  end

endmodule

// File: rtl/min_search_ctrl.sv
// Sequential minimum search over 6*GROUPS unsigned W-bit elements, one group of six per cycle.
// Optional feature macro: MIN_INDEX_EN adds index tracking and the out_idx port.
module min_search_ctrl
  import dac_min_pkg::*;
#(
  parameter int unsigned W      = DEF_W,
  parameter int unsigned GROUPS = 4
`ifdef MIN_INDEX_EN
  ,
  parameter int unsigned IDXW   = idx_width(GRP_SIZE * GROUPS)
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [GRP_SIZE*GROUPS*W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_min
`ifdef MIN_INDEX_EN
  ,
  output logic [IDXW-1:0]            out_idx
`endif
);

  localparam int unsigned GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GW-1:0] LastG = GW'(GROUPS - 1);

  state_e                        state_q;
  logic [GW-1:0]                 g_q;
  logic [GRP_SIZE*GROUPS*W-1:0]  cap_q;
  logic [W-1:0]                  run_min_q;

  logic [GRP_SIZE*W-1:0]         grp_data;
  logic [W-1:0]                  grp_min;
  logic [2:0]                    grp_lidx;
  logic                          take_grp;
  logic [W-1:0]                  nxt_min;

`ifdef MIN_INDEX_EN
  logic [IDXW-1:0]               run_idx_q;
  logic [IDXW-1:0]               grp_idx;
  logic [IDXW-1:0]               nxt_idx;
`else
  logic                          unused_lidx;
  assign unused_lidx = ^grp_lidx;
`endif

  // Select the current group of six from the captured vector
  always_comb begin
    grp_data = cap_q[int'(g_q) * GRP_SIZE * W +: GRP_SIZE * W];
  end

  min6_idx #(
    .W (W)
  ) u_min6 (
    .data_i (grp_data),
    .min_o  (grp_min),
    .idx_o  (grp_lidx)
  );

  // Running minimum: first group loads, later groups only on strictly smaller value
  always_comb begin
    take_grp = (g_q == '0) || (grp_min < run_min_q);
    nxt_min  = take_grp ? grp_min : run_min_q;
`ifdef MIN_INDEX_EN
    grp_idx  = IDXW'(int'(g_q) * GRP_SIZE + int'(grp_lidx));
    nxt_idx  = take_grp ? grp_idx : run_idx_q;
`endif
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      g_q       <= '0;
      cap_q     <= '0;
      run_min_q <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_min   <= '0;
`ifdef MIN_INDEX_EN
      run_idx_q <= '0;
      out_idx   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            cap_q    <= in_data;
            g_q      <= '0;
            in_ready <= 1'b0;
            state_q  <= StScan;
          end else begin
            in_ready <= 1'b1;
          end
        end
        StScan: begin
          run_min_q <= nxt_min;
`ifdef MIN_INDEX_EN
          run_idx_q <= nxt_idx;
`endif
          if (g_q == LastG) begin
            out_min   <= nxt_min;
`ifdef MIN_INDEX_EN
            out_idx   <= nxt_idx;
`endif
            out_valid <= 1'b1;
            g_q       <= '0;
            state_q   <= StHold;
          end else begin
            g_q <= g_q + 1'b1;
          end
        end
        StHold: begin
          // Handoff frees the block; new accept only from the following cycle
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
